usb_token_crc5_chk: RTL and testbench

- Receive-side CRC5 checker for USB token packets (OUT/IN/SETUP/SOF-style 16-bit body after the PID).
- Consumes the destuffed, NRZI-decoded serial bitstream one bit per strobe, LSB first.
- Extracts the 7-bit address and 4-bit endpoint, then runs the 5-bit CRC field through the same CRC5 LFSR and checks the residual.
- Sits between the RX bit decoder and the token/PID decoder FSM; it is the checking counterpart of usb_crc5.

---
 rtl/usb_token_crc5_chk_if.sv | 24 ++
 rtl/usb_token_crc5_chk.sv | 153 +++++++++++++++
 tb/tb_usb_token_crc5_chk.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_token_crc5_chk_if.sv
// Token-body handshake between the RX bit decoder, the CRC5 checker and the token decoder.
// The master drives the serial body and framing pulses; the slave returns the captured fields and the verdict.
interface usb_token_crc5_chk_if;
   logic       pkt_start;
   logic       bit_valid;
   logic       bit_in;
   logic       pkt_end;
   logic [6:0] addr;
   logic [3:0] endp;
   logic       token_valid;
   logic       crc_err;
   logic       len_err;
   logic       busy;

   modport master (
      output pkt_start, bit_valid, bit_in, pkt_end,
      input  addr, endp, token_valid, crc_err, len_err, busy
   );

   modport slave (
      input  pkt_start, bit_valid, bit_in, pkt_end,
      output addr, endp, token_valid, crc_err, len_err, busy
   );
endinterface

// File: rtl/usb_token_crc5_chk.sv
// Receive-side CRC5 checker for USB token bodies: captures addr/endp and checks the LFSR residual.
// Bits arrive LSB first; the verdict pulse is registered one cycle after EOP.
module usb_token_crc5_chk #(
   parameter int         BODY_BITS    = 16,
   parameter logic [4:0] CRC_RESIDUAL = 5'b01100
) (
   input  logic                clk,
   input  logic                n_rst,
   usb_token_crc5_chk_if.slave tok
);

   localparam int               CNT_W     = $clog2(BODY_BITS + 1);
   localparam logic [CNT_W-1:0] BODY_CNT  = CNT_W'(BODY_BITS);
   localparam logic [CNT_W-1:0] ENDP_BASE = CNT_W'(7);
   localparam logic [CNT_W-1:0] CRC_BASE  = CNT_W'(11);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHIFT    = 2'd1,
      ST_WAIT_EOP = 2'd2,
      ST_RESULT   = 2'd3
   } state_t;

   function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[4];
      return {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
   endfunction

   state_t           state_r;
   logic [4:0]       crc_r;
   logic [CNT_W-1:0] cnt_r;
   logic [6:0]       addr_r;
   logic [3:0]       endp_r;
   logic             ovr_r;
   logic             token_valid_r;
   logic             crc_err_r;
   logic             len_err_r;
   logic             busy_r;

   logic             in_pkt_s;
   logic             active_s;
   logic             accept_s;
   logic             ovr_hit_s;
   logic             end_s;
   logic             len_ok_s;
   logic [4:0]       crc_base_s;
   logic [CNT_W-1:0] cnt_base_s;
   logic [6:0]       addr_base_s;
   logic [3:0]       endp_base_s;
   logic             ovr_base_s;
   logic [1:0]       endp_idx_s;
   logic [4:0]       crc_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [6:0]       addr_nxt_s;
   logic [3:0]       endp_nxt_s;
   logic             ovr_nxt_s;

   // Next-state datapath: a pkt_start reseeds first so a coincident bit becomes body bit 0.
   always_comb begin
      in_pkt_s  = (state_r == ST_SHIFT) || (state_r == ST_WAIT_EOP);
      active_s  = tok.pkt_start || in_pkt_s;
      accept_s  = tok.bit_valid && (tok.pkt_start || (state_r == ST_SHIFT));
      ovr_hit_s = tok.bit_valid && !tok.pkt_start && (state_r == ST_WAIT_EOP);
      end_s     = tok.pkt_end && !tok.pkt_start && in_pkt_s;

      if (tok.pkt_start) begin
         crc_base_s  = 5'b11111;
         cnt_base_s  = '0;
         addr_base_s = 7'd0;
         endp_base_s = 4'd0;
         ovr_base_s  = 1'b0;
      end else begin
         crc_base_s  = crc_r;
         cnt_base_s  = cnt_r;
         addr_base_s = addr_r;
         endp_base_s = endp_r;
         ovr_base_s  = ovr_r;
      end

      endp_idx_s = 2'(cnt_base_s - ENDP_BASE);

      if (accept_s) begin
         crc_nxt_s = crc5_step(crc_base_s, tok.bit_in);
         cnt_nxt_s = cnt_base_s + CNT_W'(1);
      end else begin
         crc_nxt_s = crc_base_s;
         cnt_nxt_s = cnt_base_s;
      end

      addr_nxt_s = addr_base_s;
      endp_nxt_s = endp_base_s;
      if (accept_s && (cnt_base_s < ENDP_BASE)) begin
         addr_nxt_s[cnt_base_s[2:0]] = tok.bit_in;
      end else if (accept_s && (cnt_base_s < CRC_BASE)) begin
         endp_nxt_s[endp_idx_s] = tok.bit_in;
      end else begin
         addr_nxt_s = addr_base_s;
         endp_nxt_s = endp_base_s;
      end

      ovr_nxt_s = ovr_base_s || ovr_hit_s;
      len_ok_s  = (cnt_nxt_s == BODY_CNT) && !ovr_nxt_s;
   end

   // Control FSM with registered verdict pulses, busy flag and captured fields.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r       <= ST_IDLE;
         crc_r         <= 5'b11111;
         cnt_r         <= '0;
         addr_r        <= 7'd0;
         endp_r        <= 4'd0;
         ovr_r         <= 1'b0;
         token_valid_r <= 1'b0;
         crc_err_r     <= 1'b0;
         len_err_r     <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         token_valid_r <= 1'b0;
         crc_err_r     <= 1'b0;
         len_err_r     <= 1'b0;
         if (active_s) begin
            crc_r  <= crc_nxt_s;
            cnt_r  <= cnt_nxt_s;
            addr_r <= addr_nxt_s;
            endp_r <= endp_nxt_s;
            ovr_r  <= ovr_nxt_s;
         end
         if (end_s) begin
            state_r       <= ST_RESULT;
            busy_r        <= 1'b0;
            token_valid_r <= len_ok_s && (crc_nxt_s == CRC_RESIDUAL);
            crc_err_r     <= len_ok_s && (crc_nxt_s != CRC_RESIDUAL);
            len_err_r     <= !len_ok_s;
         end else if (active_s) begin
            state_r <= (cnt_nxt_s == BODY_CNT) ? ST_WAIT_EOP : ST_SHIFT;
            busy_r  <= 1'b1;
         end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
         end
      end
   end

   assign tok.addr        = addr_r;
   assign tok.endp        = endp_r;
   assign tok.token_valid = token_valid_r;
   assign tok.crc_err     = crc_err_r;
   assign tok.len_err     = len_err_r;
   assign tok.busy        = busy_r;

endmodule

// File: tb/tb_usb_token_crc5_chk.sv
// Scoreboard bench for usb_token_crc5_chk: expected verdicts are queued as packets are driven
// and compared when a result pulse appears.
module tb_usb_token_crc5_chk;

   localparam logic [2:0] R_TOK = 3'b100;
   localparam logic [2:0] R_CRC = 3'b010;
   localparam logic [2:0] R_LEN = 3'b001;

   typedef struct {
      logic [2:0] code;
      logic [6:0] addr;
      logic [3:0] endp;
   } exp_t;

   logic tb_clk = 1'b0;
   logic n_rst  = 1'b0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   exp_t exp_q[$];

   usb_token_crc5_chk_if tif ();

   usb_token_crc5_chk dut (
      .clk   (tb_clk),
      .n_rst (n_rst),
      .tok   (tif.slave)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] model_crc(input logic [16:0] body, input int nb);
      logic [4:0] c;
      logic       fb;
      c = 5'b11111;
      for (int k = 0; k < nb && k < 16; k++) begin
         fb = body[k] ^ c[4];
         c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      return c;
   endfunction

   function automatic logic [2:0] model_code(input logic [16:0] body, input int nb);
      if (nb != 16) return R_LEN;
      return (model_crc(body, nb) == 5'b01100) ? R_TOK : R_CRC;
   endfunction

   function automatic logic [16:0] good_body(input logic [6:0] a, input logic [3:0] e);
      logic [4:0]  c;
      logic [16:0] b;
      for (int k = 0; k < 32; k++) begin
         c = 5'(k);
         b = {1'b0, c, e, a};
         if (model_crc(b, 16) == 5'b01100) return b;
      end
      return 17'd0;
   endfunction

   function automatic void push_exp(input logic [2:0] code, input logic [16:0] body, input int nb);
      exp_t e;
      e.code = code;
      e.addr = 7'd0;
      e.endp = 4'd0;
      for (int k = 0; k < nb && k < 11; k++) begin
         if (k < 7) e.addr[k] = body[k];
         else       e.endp[k-7] = body[k];
      end
      exp_q.push_back(e);
   endfunction

   task automatic cyc(input logic ps, input logic bv, input logic bi, input logic pe);
      tif.pkt_start = ps;
      tif.bit_valid = bv;
      tif.bit_in    = bi;
      tif.pkt_end   = pe;
      @(posedge tb_clk);
      #1;
      tif.pkt_start = 1'b0;
      tif.bit_valid = 1'b0;
      tif.bit_in    = 1'b0;
      tif.pkt_end   = 1'b0;
   endtask

   task automatic send_pkt(input logic [16:0] body, input int nb, input bit first_with_start,
                           input bit last_with_end, input bit do_end);
      int i;
      bit ended;
      i     = 0;
      ended = 1'b0;
      if (first_with_start && nb > 0) begin
         cyc(1'b1, 1'b1, body[0], 1'b0);
         i = 1;
      end else begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk_val("busy_shift", tif.busy, 1'b1);
      while (i < nb) begin
         if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0);
         if (i == nb - 1 && last_with_end && do_end) begin
            cyc(1'b0, 1'b1, body[i], 1'b1);
            ended = 1'b1;
         end else begin
            cyc(1'b0, 1'b1, body[i], 1'b0);
         end
         i++;
      end
      if (do_end && !ended) cyc(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge tb_clk);
      #1;
      chk_val(tag, exp_q.size(), 0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Result monitor: every pulse must match the oldest queued expectation.
   always @(negedge tb_clk) begin
      logic [2:0] code;
      exp_t       e;
      code = {tif.token_valid, tif.crc_err, tif.len_err};
      if (code != 3'b000) begin
         if (exp_q.size() == 0) begin
            chk_val("unexpected_pulse", code, 3'b000);
         end else begin
            e = exp_q.pop_front();
            chk_val("result", code, e.code);
            chk_val("addr", tif.addr, e.addr);
            chk_val("endp", tif.endp, e.endp);
            chk_val("busy_result", tif.busy, 1'b0);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [16:0] zero_tok;
      logic [16:0] b;
      logic [6:0]  a;
      logic [3:0]  e;
      zero_tok      = 17'h01000;
      tif.pkt_start = 1'b0;
      tif.bit_valid = 1'b0;
      tif.bit_in    = 1'b0;
      tif.pkt_end   = 1'b0;
      repeat (3) @(posedge tb_clk);
      #1;
      chk_val("rst_addr", tif.addr, 7'd0);
      chk_val("rst_endp", tif.endp, 4'd0);
      chk_val("rst_busy", tif.busy, 1'b0);
      chk_val("rst_pulses", {tif.token_valid, tif.crc_err, tif.len_err}, 3'b000);
      n_rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // Good zero token, then the same body with CRC bit 14 flipped.
      push_exp(R_TOK, zero_tok, 16);
      send_pkt(zero_tok, 16, 1'b0, 1'b0, 1'b1);
      wait_drain("drain_good_zero");
      push_exp(R_CRC, zero_tok ^ 17'h04000, 16);
      send_pkt(zero_tok ^ 17'h04000, 16, 1'b0, 1'b0, 1'b1);
      wait_drain("drain_bad_crc");

      // Short (12 bits) and long (17 bits) bodies.
      push_exp(R_LEN, 17'h00ABC, 12);
      send_pkt(17'h00ABC, 12, 1'b0, 1'b0, 1'b1);
      wait_drain("drain_short");
      push_exp(R_LEN, 17'h1F0A5, 17);
      send_pkt(17'h1F0A5, 17, 1'b0, 1'b0, 1'b1);
      wait_drain("drain_long");

      // Restart mid-packet: only the second packet reports.
      send_pkt(17'h1FFFF, 8, 1'b0, 1'b0, 1'b0);
      push_exp(R_TOK, zero_tok, 16);
      send_pkt(zero_tok, 16, 1'b0, 1'b0, 1'b1);
      wait_drain("drain_restart");

      // Reset mid-packet.
      send_pkt(17'h1FFFF, 9, 1'b0, 1'b0, 1'b0);
      chk_val("pre_rst_addr", tif.addr, 7'h7F);
      n_rst = 1'b0;
      #1;
      chk_val("midrst_addr", tif.addr, 7'd0);
      chk_val("midrst_endp", tif.endp, 4'd0);
      chk_val("midrst_busy", tif.busy, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_val("postrst_busy", tif.busy, 1'b0);
      push_exp(R_TOK, zero_tok, 16);
      send_pkt(zero_tok, 16, 1'b0, 1'b0, 1'b1);
      wait_drain("drain_after_rst");

      // Random good and corrupted tokens, exercising start+bit and bit+end coincidence.
      for (int i = 0; i < 8; i++) begin
         a = 7'($urandom_range(0, 127));
         e = 4'($urandom_range(0, 15));
         b = good_body(a, e);
         if (i >= 4) b[$urandom_range(0, 15)] ^= 1'b1;
         push_exp(model_code(b, 16), b, 16);
         send_pkt(b, 16, i[0], i[1], 1'b1);
         wait_drain("drain_random");
      end

      // Fields hold in IDLE; stray pkt_end and bit_valid are ignored.
      a = 7'h55;
      e = 4'hA;
      b = good_body(a, e);
      push_exp(R_TOK, b, 16);
      send_pkt(b, 16, 1'b0, 1'b1, 1'b1);
      wait_drain("drain_last_good");
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_val("idle_addr_hold", tif.addr, 7'h55);
      chk_val("idle_endp_hold", tif.endp, 4'hA);
      chk_val("idle_busy", tif.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
